// File: rtl/io_rx_pkg.sv
// Shared definitions for the pad receive-capture path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package io_rx_pkg;

    typedef enum logic [1:0] {
        DRIVE   = 2'd0,
        BLANK   = 2'd1,
        CAPTURE = 2'd2,
        ILLEGAL = 2'd3
    } rx_state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int TURN_MIN  = 0;
    localparam int TURN_MAX  = 15;

    // Wide enough to hold TURN_MAX - 1.
    localparam int TURN_W = 4;

endpackage

// File: rtl/io_rx_turn_timer.sv
// Loadable down-counter timing the bus-turnaround blanking window.
// Latency: load visible next edge; done is combinational from the count.
// Backpressure: none; clr has priority over load and dec.
module io_rx_turn_timer
    import io_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              dec,
    input  logic [TURN_W-1:0] load_val,
    output logic              done
);

    logic [TURN_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - TURN_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/io_rx_capture.sv
// Pad receive path: blanks turnaround cycles, deserialises pad bits into words.
// Latency: last bit on pad_i at edge N gives dout_valid after edge N+1.
// Backpressure: valid/ready; a word completing while dout is held is dropped and flags overrun.
module io_rx_capture
    import io_rx_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pad_i,
    input  logic             t_in,
    input  logic             gts,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]     LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [TURN_W-1:0] TURN_LOAD = (TURN_CYCLES > 0) ? TURN_W'(TURN_CYCLES - 1) : '0;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("io_rx_capture: WIDTH outside legal range");
    end
    if (TURN_CYCLES < TURN_MIN || TURN_CYCLES > TURN_MAX) begin : g_bad_turn
        $error("io_rx_capture: TURN_CYCLES outside legal range");
    end

    rx_state_e        state;
    rx_state_e        state_nxt;
    logic             rx_en;
    logic             pad_r;
    logic             shift_en;
    logic             word_done;
    logic             drop;
    logic             turn_load;
    logic             turn_dec;
    logic             turn_done;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_nxt;
    logic [CW-1:0]    bit_cnt;

    assign rx_en = t_in | gts;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DRIVE;
        end else begin
            state <= state_nxt;
        end
    end

    // Losing receive permission wins from every state, including the unused encoding.
    always_comb begin
        state_nxt = state;
        if (!rx_en) begin
            state_nxt = DRIVE;
        end else begin
            case (state)
                DRIVE:   state_nxt = (TURN_CYCLES > 0) ? BLANK : CAPTURE;
                BLANK:   if (turn_done) state_nxt = CAPTURE;
                CAPTURE: state_nxt = CAPTURE;
                default: state_nxt = DRIVE;
            endcase
        end
    end

    assign turn_load = (state == DRIVE) && rx_en && (TURN_CYCLES > 0);
    assign turn_dec  = (state == BLANK) && rx_en;

    io_rx_turn_timer u_turn_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (!rx_en),
        .load     (turn_load),
        .dec      (turn_dec),
        .load_val (TURN_LOAD),
        .done     (turn_done)
    );

    assign shift_en  = (state == CAPTURE) && rx_en;
    assign word_done = shift_en && (bit_cnt == LAST_BIT);
    assign drop      = word_done && dout_valid && !dout_ready;
    assign busy      = (state == BLANK) || (state == CAPTURE);

    // LSB-first enters at the top and walks down, so the first bit settles in bit 0.
    always_comb begin
        if (MSB_FIRST) begin
            shift_nxt = {shreg[WIDTH-2:0], pad_r};
        end else begin
            shift_nxt = {pad_r, shreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_r   <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            pad_r <= pad_i;
            if (!rx_en) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg   <= shift_nxt;
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (word_done && (!dout_valid || dout_ready)) begin
                dout       <= shift_nxt;
                dout_valid <= 1'b1;
            end else if (!word_done && dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_rx_capture.sv
// Three differently parameterised captures share one pad stream; each is checked
// every cycle against a bit-list reference model plus directed constant expectations.
module tb_io_rx_capture;

    localparam int NI = 3;
    localparam int P_W   [NI] = '{8, 8, 5};
    localparam int P_TC  [NI] = '{2, 0, 3};
    localparam int P_MSB [NI] = '{0, 1, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pad_i = 1'b0;
    logic t_in = 1'b0;
    logic gts = 1'b0;
    logic dout_ready = 1'b0;
    logic clr_overrun = 1'b0;

    logic [7:0] dout_a, dout_b;
    logic [4:0] dout_c;
    logic vld_a, vld_b, vld_c;
    logic ovr_a, ovr_b, ovr_c;
    logic busy_a, busy_b, busy_c;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    io_rx_capture #(.WIDTH(P_W[0]), .TURN_CYCLES(P_TC[0]), .MSB_FIRST(P_MSB[0] != 0)) u_a (
        .clk(clk), .rst(rst), .pad_i(pad_i), .t_in(t_in), .gts(gts),
        .dout(dout_a), .dout_valid(vld_a), .dout_ready(dout_ready),
        .overrun(ovr_a), .clr_overrun(clr_overrun), .busy(busy_a));

    io_rx_capture #(.WIDTH(P_W[1]), .TURN_CYCLES(P_TC[1]), .MSB_FIRST(P_MSB[1] != 0)) u_b (
        .clk(clk), .rst(rst), .pad_i(pad_i), .t_in(t_in), .gts(gts),
        .dout(dout_b), .dout_valid(vld_b), .dout_ready(dout_ready),
        .overrun(ovr_b), .clr_overrun(clr_overrun), .busy(busy_b));

    io_rx_capture #(.WIDTH(P_W[2]), .TURN_CYCLES(P_TC[2]), .MSB_FIRST(P_MSB[2] != 0)) u_c (
        .clk(clk), .rst(rst), .pad_i(pad_i), .t_in(t_in), .gts(gts),
        .dout(dout_c), .dout_valid(vld_c), .dout_ready(dout_ready),
        .overrun(ovr_c), .clr_overrun(clr_overrun), .busy(busy_c));

    logic [31:0] o_dout [NI];
    logic        o_vld  [NI];
    logic        o_ovr  [NI];
    logic        o_busy [NI];

    assign o_dout[0] = 32'(dout_a);
    assign o_dout[1] = 32'(dout_b);
    assign o_dout[2] = 32'(dout_c);
    assign o_vld[0] = vld_a;
    assign o_vld[1] = vld_b;
    assign o_vld[2] = vld_c;
    assign o_ovr[0] = ovr_a;
    assign o_ovr[1] = ovr_b;
    assign o_ovr[2] = ovr_c;
    assign o_busy[0] = busy_a;
    assign o_busy[1] = busy_b;
    assign o_busy[2] = busy_c;

    // Reference model: receive window age plus a list of captured bit positions.
    bit          m_in   [NI];
    int          m_age  [NI];
    int          m_n    [NI];
    logic [31:0] m_acc  [NI];
    logic [31:0] m_dout [NI];
    logic        m_vld  [NI];
    logic        m_ovr  [NI];
    logic        m_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit          done;
        bit          drop;
        int          pos;
        logic [31:0] word;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_in[i] = 1'b0; m_age[i] = 0; m_n[i] = 0; m_acc[i] = '0;
                m_dout[i] = '0; m_vld[i] = 1'b0; m_ovr[i] = 1'b0;
            end else begin
                done = 1'b0;
                word = '0;
                if (!(t_in || gts)) begin
                    m_in[i] = 1'b0; m_n[i] = 0; m_acc[i] = '0;
                end else if (!m_in[i]) begin
                    m_in[i] = 1'b1; m_age[i] = 0; m_n[i] = 0; m_acc[i] = '0;
                end else begin
                    m_age[i]++;
                    if (m_age[i] > P_TC[i]) begin
                        pos = (P_MSB[i] != 0) ? P_W[i] - 1 - m_n[i] : m_n[i];
                        m_acc[i][pos] = m_prev;
                        m_n[i]++;
                        if (m_n[i] == P_W[i]) begin
                            done = 1'b1; word = m_acc[i]; m_n[i] = 0; m_acc[i] = '0;
                        end
                    end
                end
                drop = 1'b0;
                if (done) begin
                    if (!m_vld[i] || dout_ready) begin
                        m_dout[i] = word; m_vld[i] = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (m_vld[i] && dout_ready) begin
                    m_vld[i] = 1'b0;
                end
                if (drop) m_ovr[i] = 1'b1;
                else if (clr_overrun) m_ovr[i] = 1'b0;
            end
        end
        m_prev = rst ? 1'b0 : pad_i;
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("dout%0d", i), o_dout[i], m_dout[i]);
            chk($sformatf("valid%0d", i), 32'(o_vld[i]), 32'(m_vld[i]));
            chk($sformatf("overrun%0d", i), 32'(o_ovr[i]), 32'(m_ovr[i]));
            chk($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(m_in[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic drive(input logic p);
        pad_i = p;
        step();
    endtask

    task automatic send_word(input logic [31:0] w, input int n, input bit msb);
        for (int k = 0; k < n; k++) drive(msb ? w[n-1-k] : w[k]);
    endtask

    task automatic settle();
        t_in = 1'b0; gts = 1'b0; clr_overrun = 1'b1; dout_ready = 1'b1;
        step();
        step();
        clr_overrun = 1'b0; dout_ready = 1'b0;
    endtask

    initial begin
        int          pulse_cyc [$];
        logic [31:0] pulse_word [$];
        logic [31:0] w1, w2, b2b;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_dout", 32'(dout_a), 32'h0);
        chk("rst_valid", 32'(vld_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        rst = 1'b0;
        step();

        // Turnaround blanking: two blanked 1s then 0xA5 LSB-first
        t_in = 1'b1;
        drive(1'b1);
        drive(1'b1);
        send_word(32'hA5, 8, 1'b0);
        pad_i = 1'b0;
        step();
        chk("turn_dout", 32'(dout_a), 32'hA5);
        chk("turn_valid", 32'(vld_a), 32'h1);

        // Back-to-back words on the zero-turnaround MSB-first instance
        settle();
        dout_ready = 1'b1;
        t_in = 1'b1;
        b2b = 32'h3CC3;
        for (int k = 0; k < 18; k++) begin
            pad_i = (k < 16) ? b2b[15-k] : 1'b0;
            step();
            if (vld_b) begin
                pulse_cyc.push_back(cyc);
                pulse_word.push_back(32'(dout_b));
            end
        end
        chk("b2b_pulses", 32'(pulse_cyc.size()), 32'd2);
        if (pulse_cyc.size() == 2) begin
            chk("b2b_gap", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd8);
            chk("b2b_word0", pulse_word[0], 32'h3C);
            chk("b2b_word1", pulse_word[1], 32'hC3);
        end
        chk("b2b_overrun", 32'(ovr_b), 32'h0);

        // Overrun and clear
        settle();
        w1 = 32'($urandom_range(255));
        w2 = 32'($urandom_range(255));
        t_in = 1'b1;
        drive(1'b0);
        drive(1'b0);
        send_word(w1, 8, 1'b0);
        send_word(w2, 8, 1'b0);
        step();
        chk("ovr_keep", 32'(dout_a), w1);
        chk("ovr_set", 32'(ovr_a), 32'h1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("ovr_clear", 32'(ovr_a), 32'h0);

        // Abort after five bits, then a clean 0x81
        settle();
        t_in = 1'b1;
        drive(1'b1);
        drive(1'b1);
        send_word(32'h1F, 5, 1'b0);
        t_in = 1'b0;
        drive(1'b1);
        t_in = 1'b1;
        drive(1'b1);
        drive(1'b1);
        send_word(32'h81, 8, 1'b0);
        step();
        chk("abort_dout", 32'(dout_a), 32'h81);
        chk("abort_ovr", 32'(ovr_a), 32'h0);

        // gts override, MSB-first
        settle();
        gts = 1'b1;
        send_word(32'h80, 8, 1'b1);
        step();
        chk("gts_dout", 32'(dout_b), 32'h80);
        chk("gts_valid", 32'(vld_b), 32'h1);

        // Reset after three captured bits, then a full word
        settle();
        t_in = 1'b1;
        drive(1'b1);
        drive(1'b1);
        send_word(32'h7, 3, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_dout", 32'(dout_a), 32'h0);
        chk("mrst_valid", 32'(vld_a), 32'h0);
        chk("mrst_busy", 32'(busy_a), 32'h0);
        w1 = 32'($urandom_range(255));
        drive(1'b1);
        drive(1'b1);
        send_word(w1, 8, 1'b0);
        step();
        chk("mrst_word", 32'(dout_a), w1);

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(15) == 0) t_in = ~t_in;
            if ($urandom_range(31) == 0) gts = ~gts;
            pad_i       = 1'($urandom_range(1));
            dout_ready  = 1'($urandom_range(1));
            clr_overrun = ($urandom_range(15) == 0);
            rst         = ($urandom_range(255) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_rx_capture.md
Name: io_rx_capture

Overview:
- Receive-side companion to the tristate pad output driver.
- Samples the pad input only while the local output driver is released (T=1 or global tristate asserted).
- Blanks a programmable number of bus-turnaround cycles, then deserialises the pad bit stream into WIDTH-bit words.
- Presents each word on a valid/ready interface toward the controller read path.

Parameters:
- WIDTH, 8, bits per assembled word; legal 2..32.
- TURN_CYCLES, 2, cycles discarded after the driver releases the pad; legal 0..15.
- MSB_FIRST, 0, 0 = first received bit lands in dout[0]; 1 = first received bit lands in dout[WIDTH-1].

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- pad_i  input  1  pad input value, already in the clk domain.
- t_in  input  1  copy of the output driver's T; 1 = driver off, receive allowed.
- gts  input  1  global tristate; 1 forces receive-allowed, the same as t_in=1.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- overrun  output  1  sticky: a completed word was dropped.
- clr_overrun  input  1  clears overrun.
- busy  output  1  state is BLANK or CAPTURE.

Behaviour:
- Reset values: dout=0, dout_valid=0, overrun=0, busy=0, state=DRIVE, bit_cnt=0, turn_cnt=0, pad_r=0.
- rx_en = t_in | gts.
- pad_r registers pad_i every cycle, regardless of state.
- DRIVE:
  - rx_en=1 and TURN_CYCLES>0: go to BLANK and load turn_cnt=TURN_CYCLES-1.
  - rx_en=1 and TURN_CYCLES=0: go directly to CAPTURE.
- BLANK:
  - pad_r is ignored.
  - turn_cnt decrements each cycle; at turn_cnt=0 go to CAPTURE on the next edge.
  - The number of BLANK cycles equals TURN_CYCLES exactly.
- CAPTURE:
  - Each cycle, shift pad_r into the shift register in the order set by MSB_FIRST, and increment bit_cnt.
  - On the edge that shifts bit WIDTH-1, the completed word is offered to the output register and bit_cnt wraps to 0. Capture continues with no gap cycle.
- Leaving receive: if rx_en=0 in any state, go to DRIVE on the next edge. A partial word is discarded and bit_cnt and turn_cnt are cleared. The output register is untouched.
- Output register:
  - On word completion, if dout_valid=0, or dout_valid=1 with dout_ready=1 in the same cycle, load dout and set dout_valid=1.
  - If dout_valid=1 and dout_ready=0, the new word is dropped, dout is kept, and overrun is set.
  - dout_ready with dout_valid and no new word completing clears dout_valid.
  - dout_ready while dout_valid=0 is ignored.
- Latency: the last bit of a word on pad_i at edge N gives dout_valid=1 after edge N+1.
- overrun:
  - clr_overrun clears it on the next edge.
  - If clr_overrun and a new drop occur in the same cycle, set wins.
- Reset mid-operation: returns to the reset values in one edge and discards any shift contents.
- The bit counter is clog2(WIDTH) bits wide; no other arithmetic.

Decomposition:
- Shared package io_rx_pkg holds:
  - state encoding: DRIVE=2'd0, BLANK=2'd1, CAPTURE=2'd2 (2'd3 is illegal and recovers to DRIVE);
  - the TURN_CYCLES and WIDTH legal-range constants, used for elaboration-time checks.
- One natural sub-module, io_rx_turn_timer: a loadable down-counter with a done flag, used for the BLANK phase.
- The shift register and output register stay in the top module.

Test Plan:
- Turnaround blanking: WIDTH=8, TURN_CYCLES=2, LSB-first. Raise t_in at edge 0, drive pad_i=1 for 2 cycles, then 0xA5 LSB-first. Required: dout=0xA5 and dout_valid=1 ten edges after the t_in rise; the blanked 1s are absent.
- Back-to-back words: TURN_CYCLES=0, dout_ready held 1, stream 0x3C then 0xC3 contiguously. Required: two dout_valid pulses exactly 8 cycles apart, and overrun=0.
- Overrun and clear: dout_ready=0, stream two words. Required: dout keeps the first word, overrun=1. Then clr_overrun=1 for 1 cycle gives overrun=0.
- Abort mid-word: drop t_in after 5 bits, then re-enable and send 0x81. Required: dout=0x81 and no corrupt partial word.
- gts override and MSB_FIRST=1: hold t_in=0, gts=1, send bits 1,0,0,0,0,0,0,0. Required: dout=0x80.
- Reset mid-word: assert rst for 1 cycle after 3 captured bits. Required: all outputs at reset values; the following full word is received correctly after the turnaround.
